// File: rtl/serial_adder_n.sv
// serial_adder_n
// Digit-serial adder: accepts two WIDTH-bit operands plus a carry-in, adds
// them DIGIT bits per clock (least-significant slice first) and presents
// the WIDTH-bit result with carry-out and signed overflow behind a
// valid/ready handshake.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per cycle; must divide WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/cin (and op) are valid
//   in_ready   block idle and able to accept operands
//   a, b       operands
//   cin        carry-in (ignored when subtracting)
//   op         0 = add, 1 = subtract (only with SERADD_SUB_EN)
//   out_valid  sum/cout/overflow are valid
//   out_ready  consumer takes the result
//   sum        result
//   cout       carry out of the MSB (1 = no borrow when subtracting)
//   overflow   two's-complement overflow
//
// Optional feature macro: SERADD_SUB_EN (adds the op port and subtraction).
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERADD_SUB_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;
    logic [DIGIT:0]   slice_s;
    logic [WIDTH-1:0] slice_ext_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             msb_cin_s;
    logic             last_s;
    logic             in_ready_s;
    logic             out_valid_s;

    // Adds one DIGIT-wide slice with carry; the top bit is the slice carry-out.
    function automatic logic [DIGIT:0] slice_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
    endfunction

    // Operand conditioning: subtraction is a + ~b + 1, so invert b and force carry.
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
`ifdef SERADD_SUB_EN
        if (op) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // Slice arithmetic and result assembly for the current RUN cycle.
    always_comb begin
        slice_s     = slice_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
        slice_ext_s = '0;
        slice_ext_s[DIGIT-1:0] = slice_s[DIGIT-1:0];
        // New slice enters at the top; after N shifts slice 0 sits at bit 0.
        acc_next_s  = (acc_r >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_cin_s   = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_s[DIGIT-1];
        last_s      = (cnt_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_s = RUN;  else state_s = IDLE;
            RUN:     if (last_s)    state_s = DONE; else state_s = RUN;
            DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, per-slice accumulation, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b_load_s;
                        carry_r <= carry_load_s;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    acc_r   <= acc_next_s;
                    carry_r <= slice_s[DIGIT];
                    cnt_r   <= cnt_r + CNT_ONE;
                    // Visible outputs change only when the full result is ready.
                    if (last_s) begin
                        sum_r  <= acc_next_s;
                        cout_r <= slice_s[DIGIT];
                        ovf_r  <= msb_cin_s ^ slice_s[DIGIT];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;

endmodule
